// File: rtl/control_obstaculos.sv
// -----------------------------------------------------------------------------
// control_obstaculos
//
// Obstacle sequencer for the game datapath. A free-running LFSR picks an
// obstacle type that is sent to the obstacle ROM. The returned 7-bit pattern is
// scrolled through a FILAS-row playfield toward the player row. Each game step
// ends with a collision check and a score update.
//
// Optional feature: define ACELERACION_EN to shorten the step period each time
// the score reaches a multiple of 8. The period never goes below TICK_MIN.
// Without the macro the period is the constant TICK_DIV.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   inicio     start / restart request (level)
//   pausa      freezes the step timer while high (ESPERA only)
//   jugador    player lane mask
//   obstaculo  pattern from the combinational obstacle ROM
//   tipo_obs   obstacle type driven to the ROM (registered)
//   campo      playfield, row i at bits [7*i+6 : 7*i], row 0 = spawn row
//   puntos     score, saturating at 255
//   choque     collision flag (FIN)
//   activo     high while a game is running
//   paso       one-cycle pulse during the collision-check cycle
// -----------------------------------------------------------------------------
module control_obstaculos #(
   parameter int          FILAS    = 8,
   parameter logic [23:0] TICK_DIV = 24'd5000000,
   parameter int          ESPACIO  = 2,
   parameter logic [7:0]  SEMILLA  = 8'hA5,
   parameter logic [23:0] TICK_MIN = 24'd1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inicio,
   input  logic               pausa,
   input  logic [6:0]         jugador,
   input  logic [6:0]         obstaculo,
   output logic [3:0]         tipo_obs,
   output logic [7*FILAS-1:0] campo,
   output logic [7:0]         puntos,
   output logic               choque,
   output logic               activo,
   output logic               paso
);

   typedef enum logic [2:0] {
      IDLE,
      ESPERA,
      CARGA,
      DESPLAZA,
      CHEQUEO,
      FIN
   } estado_t;

   localparam logic [3:0] HUECO_MAX = 4'(ESPACIO - 1);

   estado_t     estado;
   logic [7:0]  lfsr;
   logic [23:0] tick;
   logic [3:0]  hueco;
   logic [23:0] periodo;

   logic [3:0]  r;
   logic [3:0]  tipo_lfsr;
   logic [6:0]  fila_jugador;
   logic [6:0]  fila_nueva;

   // Fold the low LFSR nibble into 0..9.
   assign r            = lfsr[3:0];
   assign tipo_lfsr    = (r < 4'd10) ? r : r - 4'd10;
   assign fila_jugador = campo[7*FILAS-1 -: 7];
   // An empty row is inserted while the spacing counter is nonzero.
   assign fila_nueva   = (hueco == 4'd0) ? obstaculo : 7'd0;

   // The LFSR runs in every state, so the time spent in IDLE seeds the game.
   // Taps x^8+x^6+x^5+x^4+1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr <= SEMILLA;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

`ifdef ACELERACION_EN
   logic        arranque;
   logic        sube_ocho;
   logic [23:0] periodo_rest;

   assign arranque     = ((estado == IDLE) || (estado == FIN)) && inicio;
   // The score is about to step onto a multiple of 8. The sum 255 -> 256 is
   // excluded because the score saturates.
   assign sube_ocho    = (estado == CHEQUEO) && ((fila_jugador & jugador) == 7'd0) &&
                         (fila_jugador != 7'd0) && (puntos[2:0] == 3'b111) &&
                         (puntos != 8'hFF);
   assign periodo_rest = periodo - (periodo >> 3);

   always_ff @(posedge clk) begin
      if (!rst_n || arranque) begin
         periodo <= TICK_DIV;
      end else if (sube_ocho) begin
         periodo <= (periodo_rest < TICK_MIN) ? TICK_MIN : periodo_rest;
      end
   end
`else
   // TICK_MIN has no effect without acceleration.
   assign periodo = TICK_DIV | (TICK_MIN & 24'd0);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado   <= IDLE;
         campo    <= '0;
         puntos   <= 8'd0;
         choque   <= 1'b0;
         activo   <= 1'b0;
         paso     <= 1'b0;
         tipo_obs <= 4'd0;
         tick     <= 24'd0;
         hueco    <= 4'd0;
      end else begin
         paso <= 1'b0;
         case (estado)
            IDLE, FIN: begin
               if (inicio) begin
                  campo  <= '0;
                  puntos <= 8'd0;
                  choque <= 1'b0;
                  tick   <= 24'd0;
                  hueco  <= 4'd0;
                  activo <= 1'b1;
                  estado <= ESPERA;
               end
            end

            ESPERA: begin
               if (!pausa) begin
                  if (tick == periodo - 24'd1) begin
                     tick   <= 24'd0;
                     estado <= CARGA;
                  end else begin
                     tick <= tick + 24'd1;
                  end
               end
            end

            CARGA: begin
               // The ROM answers combinationally. Its output is captured one
               // cycle later in DESPLAZA.
               if (hueco == 4'd0) begin
                  tipo_obs <= tipo_lfsr;
               end
               estado <= DESPLAZA;
            end

            DESPLAZA: begin
               campo  <= {campo[7*FILAS-8:0], fila_nueva};
               hueco  <= (hueco == 4'd0) ? HUECO_MAX : hueco - 4'd1;
               paso   <= 1'b1;
               estado <= CHEQUEO;
            end

            CHEQUEO: begin
               if ((fila_jugador & jugador) != 7'd0) begin
                  choque <= 1'b1;
                  activo <= 1'b0;
                  estado <= FIN;
               end else begin
                  if ((fila_jugador != 7'd0) && (puntos != 8'hFF)) begin
                     puntos <= puntos + 8'd1;
                  end
                  estado <= ESPERA;
               end
            end

            default: begin
               estado <= IDLE;
               activo <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_obstaculos.sv
// -----------------------------------------------------------------------------
// tb_control_obstaculos
//
// Bench for control_obstaculos with FILAS=4, TICK_DIV=4 and ESPACIO=2. The bench
// holds a small ROM and a behavioural game model. The model tracks the position
// inside a step as a cycle count, keeps the rows as an array and computes the
// obstacle type arithmetically. Every DUT output is compared against the model
// on each falling edge. The bench prints one line per game step.
// -----------------------------------------------------------------------------
module tb_control_obstaculos;

   localparam int          FILAS    = 4;
   localparam logic [23:0] TICK_DIV = 24'd4;
   localparam int          ESPACIO  = 2;
   localparam logic [7:0]  SEMILLA  = 8'hA5;
   localparam logic [23:0] TICK_MIN = 24'd3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               inicio = 1'b0;
   logic               pausa = 1'b0;
   logic [6:0]         jugador = 7'd0;
   logic [6:0]         obstaculo;
   logic [3:0]         tipo_obs;
   logic [7*FILAS-1:0] campo;
   logic [7:0]         puntos;
   logic               choque;
   logic               activo;
   logic               paso;

   logic               force_rom = 1'b0;
   logic [6:0]         force_pat = 7'd0;

   always #5 clk = ~clk;

   control_obstaculos #(
      .FILAS    (FILAS),
      .TICK_DIV (TICK_DIV),
      .ESPACIO  (ESPACIO),
      .SEMILLA  (SEMILLA),
      .TICK_MIN (TICK_MIN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inicio    (inicio),
      .pausa     (pausa),
      .jugador   (jugador),
      .obstaculo (obstaculo),
      .tipo_obs  (tipo_obs),
      .campo     (campo),
      .puntos    (puntos),
      .choque    (choque),
      .activo    (activo),
      .paso      (paso)
   );

   function automatic logic [6:0] rom(input logic [3:0] t);
      case (t)
         4'd0:    return 7'b1100011;
         4'd1:    return 7'b0011100;
         4'd2:    return 7'b1000001;
         4'd3:    return 7'b0111110;
         4'd4:    return 7'b0001000;
         4'd5:    return 7'b1110000;
         4'd6:    return 7'b0000111;
         4'd7:    return 7'b1010101;
         4'd8:    return 7'b0100010;
         4'd9:    return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   always_comb obstaculo = force_rom ? force_pat : rom(tipo_obs);

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_mode;          // 0 idle, 1 running, 2 game over
   int         m_pos;           // cycle within step: 0..per-1 wait, per load, per+1 shift, per+2 check
   int         m_per;
   int         m_hueco;
   int         m_pts;
   int         m_steps;
   logic [6:0] m_rows [FILAS];
   logic [3:0] m_tipo;
   logic [7:0] m_lfsr;

   task automatic model_reset();
      m_mode  = 0;
      m_pos   = 0;
      m_per   = int'(TICK_DIV);
      m_hueco = 0;
      m_pts   = 0;
      m_tipo  = 4'd0;
      m_lfsr  = SEMILLA;
      for (int i = 0; i < FILAS; i++) m_rows[i] = 7'd0;
   endtask

   task automatic model_edge();
      logic [7:0] l_old;
      if (!rst_n) begin
         model_reset();
         return;
      end
      l_old  = m_lfsr;
      m_lfsr = ((l_old << 1) & 8'hFF) | {7'd0, ^(l_old & 8'hB8)};
      if (m_mode != 1) begin
         if (inicio) begin
            m_mode  = 1;
            m_pos   = 0;
            m_hueco = 0;
            m_pts   = 0;
            m_per   = int'(TICK_DIV);
            for (int i = 0; i < FILAS; i++) m_rows[i] = 7'd0;
         end
      end else if (m_pos < m_per) begin
         if (!pausa) m_pos++;
      end else if (m_pos == m_per) begin
         if (m_hueco == 0) m_tipo = 4'((l_old & 8'h0F) % 10);
         m_pos++;
      end else if (m_pos == m_per + 1) begin
         for (int i = FILAS - 1; i > 0; i--) m_rows[i] = m_rows[i-1];
         m_rows[0] = (m_hueco == 0) ? (force_rom ? force_pat : rom(m_tipo)) : 7'd0;
         m_hueco   = (m_hueco == 0) ? ESPACIO - 1 : m_hueco - 1;
         m_pos++;
      end else begin
         if ((m_rows[FILAS-1] & jugador) != 7'd0) begin
            m_mode = 2;
         end else if (m_rows[FILAS-1] != 7'd0 && m_pts < 255) begin
            m_pts++;
`ifdef ACELERACION_EN
            if (m_pts % 8 == 0) begin
               m_per = m_per - m_per / 8;
               if (m_per < int'(TICK_MIN)) m_per = int'(TICK_MIN);
            end
`endif
         end
         m_pos = 0;
      end
   endtask

   task automatic compare_all();
      logic [7*FILAS-1:0] e_campo;
      logic               e_paso;
      for (int i = 0; i < FILAS; i++) e_campo[7*i +: 7] = m_rows[i];
      e_paso = (m_mode == 1) && (m_pos == m_per + 2);
      chk("campo",    64'(campo),    64'(e_campo));
      chk("puntos",   64'(puntos),   64'(m_pts));
      chk("tipo_obs", 64'(tipo_obs), 64'(m_tipo));
      chk("choque",   64'(choque),   64'(m_mode == 2));
      chk("activo",   64'(activo),   64'(m_mode == 1));
      chk("paso",     64'(paso),     64'(e_paso));
      if (e_paso) begin
         m_steps++;
         $display("step %0d tipo=%0d jugador=%b fila_jugador=%b puntos=%0d",
                  m_steps, m_tipo, jugador, m_rows[FILAS-1], m_pts);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [6:0] rand_jugador();
      case ($urandom % 4)
         0:       return 7'd0;
         3:       return 7'($urandom_range(1, 127));
         default: return 7'(1 << ($urandom % 7));
      endcase
   endfunction

   int pausa_cnt = 0;
   int bound;

   initial begin
      m_steps = 0;
      model_reset();

      // Reset held with inicio high, then released with inicio low.
      rst_n  = 1'b0;
      inicio = 1'b1;
      repeat (3) cycle();
      chk("rst_campo",  64'(campo),    64'd0);
      chk("rst_puntos", 64'(puntos),   64'd0);
      chk("rst_tipo",   64'(tipo_obs), 64'd0);
      chk("rst_activo", 64'(activo),   64'd0);
      rst_n  = 1'b1;
      inicio = 1'b0;
      repeat (5) cycle();
      chk("idle_stay", 64'(activo), 64'd0);

      // Directed collision: forced pattern overlaps lane 0.
      force_rom = 1'b1;
      force_pat = 7'b1100011;
      jugador   = 7'b0000001;
      inicio    = 1'b1;
      cycle();
      inicio = 1'b0;
      repeat (40) cycle();
      chk("dir_choque", 64'(choque), 64'd1);
      chk("dir_activo", 64'(activo), 64'd0);
      inicio = 1'b1;
      cycle();
      inicio = 1'b0;
      chk("restart_campo",  64'(campo),  64'd0);
      chk("restart_puntos", 64'(puntos), 64'd0);
      chk("restart_activo", 64'(activo), 64'd1);
      force_rom = 1'b0;

      // Randomized play: restarts, ignored inicio, pauses, occasional resets.
      for (int n = 0; n < 4000; n++) begin
         if (n % 150 == 0) jugador = rand_jugador();
         inicio = ($urandom % 30 == 0);
         rst_n  = ($urandom % 1500 != 0);
         if (pausa_cnt > 0) begin
            pausa_cnt--;
            pausa = 1'b1;
         end else if ($urandom % 40 == 0) begin
            pausa_cnt = $urandom_range(1, 12);
            pausa     = 1'b1;
         end else begin
            pausa = 1'b0;
         end
         cycle();
      end

      // Score saturation: no overlap, pattern every other step.
      pausa     = 1'b0;
      inicio    = 1'b0;
      rst_n     = 1'b0;
      cycle();
      rst_n     = 1'b1;
      force_rom = 1'b1;
      force_pat = 7'b1100011;
      jugador   = 7'b0000100;
      inicio    = 1'b1;
      cycle();
      inicio = 1'b0;
      bound  = 0;
      while (m_pts < 255 && bound < 6000) begin
         cycle();
         bound++;
      end
      chk("sat_reached", 64'(bound < 6000), 64'd1);
      repeat (150) cycle();
      chk("sat_puntos", 64'(puntos), 64'd255);
      chk("sat_activo", 64'(activo), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
